// File: rtl/rr_req_ack_arbiter.sv
// rtl/rr_req_ack_arbiter.sv - round-robin req/rdy arbiter with ack/nack pulses and fixed service time
module rr_req_ack_arbiter #(
    parameter int N          = 4,
    parameter int SVC_CYCLES = 3,
    parameter int CNT_W      = 16,
    localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     rdy,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     nack,
    output logic [IW-1:0]    grant_idx,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [3:0]    svc_cnt;

    logic [N-1:0]  elig;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_mask;
    logic [IW-1:0] ptr_next;

    assign elig = req & rdy;

    // Pick the first eligible requester at or above the pointer, wrapping to 0
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!win_found && elig[(int'(ptr) + k) % N]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr) + k) % N);
            end
        end
        win_mask          = '0;
        win_mask[win_idx] = 1'b1;
        ptr_next          = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
    end

    // Grant/reject FSM; ack and nack are rebuilt every edge so they only pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            svc_cnt   <= '0;
            ack       <= '0;
            nack      <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            grant_cnt <= '0;
        end else begin
            ack  <= '0;
            nack <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        ack       <= win_mask;
                        nack      <= elig & ~win_mask;
                        grant_idx <= win_idx;
                        ptr       <= ptr_next;
                        if (grant_cnt != '1) begin
                            grant_cnt <= grant_cnt + CNT_W'(1);
                        end
                        if (SVC_CYCLES > 1) begin
                            state   <= BUSY;
                            svc_cnt <= 4'(SVC_CYCLES - 1);
                            busy    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    nack <= elig;
                    if (svc_cnt == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        svc_cnt <= svc_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ack_nack_excl: assert property (@(posedge clk) disable iff (rst) (ack & nack) == '0);
    a_ack_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot0(ack));

    for (genvar i = 0; i < N; i++) begin : g_resp
        a_answered: assert property (@(posedge clk) disable iff (rst)
                                     elig[i] |=> (ack[i] ^ nack[i]));
        a_silent:   assert property (@(posedge clk) disable iff (rst)
                                     !elig[i] |=> (!ack[i] && !nack[i]));
    end

endmodule

// File: tb/tb_rr_req_ack_arbiter.sv
// tb/tb_rr_req_ack_arbiter.sv - randomized bench for rr_req_ack_arbiter against an edge-level model
module tb_rr_req_ack_arbiter;

    localparam int SVC = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, rdy = '0;
    logic [3:0]  ack, nack;
    logic [1:0]  grant_idx;
    logic        busy;
    logic [15:0] grant_cnt;

    logic [3:0]  req2 = '0, rdy2 = '0;
    logic [3:0]  ack2, nack2;
    logic [1:0]  grant_idx2;
    logic        busy2;
    logic [1:0]  grant_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: resource is free again at edge number next_free
    int          edge_no, next_free, m_ptr;
    logic [3:0]  m_ack, m_nack;
    logic [1:0]  m_gidx;
    logic        m_busy;
    logic [15:0] m_cnt;

    rr_req_ack_arbiter #(.N(4), .SVC_CYCLES(SVC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .rdy(rdy), .ack(ack), .nack(nack),
        .grant_idx(grant_idx), .busy(busy), .grant_cnt(grant_cnt)
    );

    rr_req_ack_arbiter #(.N(4), .SVC_CYCLES(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req(req2), .rdy(rdy2), .ack(ack2), .nack(nack2),
        .grant_idx(grant_idx2), .busy(busy2), .grant_cnt(grant_cnt2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        edge_no = 0; next_free = 0; m_ptr = 0;
        m_ack = '0; m_nack = '0; m_gidx = '0; m_busy = 1'b0; m_cnt = '0;
    endtask

    task automatic tick(input logic [3:0] r, input logic [3:0] d);
        logic [3:0] el;
        int w;
        req = r; rdy = d; el = r & d;
        @(posedge clk);
        edge_no++;
        if (edge_no >= next_free && el != 0) begin
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && el[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            m_ack  = 4'b0001 << w;
            m_nack = el & ~m_ack;
            m_gidx = 2'(w);
            m_ptr  = (w + 1) % 4;
            if (m_cnt != 16'hFFFF) m_cnt++;
            next_free = edge_no + SVC;
        end else if (edge_no >= next_free) begin
            m_ack = '0; m_nack = '0;
        end else begin
            m_ack = '0; m_nack = el;
        end
        m_busy = (edge_no + 1 < next_free);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; rdy = '0; req2 = '0; rdy2 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; rdy = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ack, nack, busy, grant_cnt} !== 25'd0) begin
                n_bad++;
                $display("FAIL reset_hold: ack=%b nack=%b busy=%b cnt=%0d, want all 0", ack, nack, busy, grant_cnt);
            end
        end
        rst = 1'b0;
        model_reset();
        tick(4'hF, 4'hF);
        n_cmp++;
        if (ack !== 4'b0001 || grant_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_first_grant: ack=%b idx=%0d, want 0001 idx 0", ack, grant_idx);
        end
    endtask

    task automatic test_single();
        do_reset();
        tick(4'b0001, 4'b0001);
        n_cmp++;
        if ({ack, nack, grant_idx, busy, grant_cnt} !== {4'b0001, 4'b0000, 2'd0, 1'b1, 16'd1}) begin
            n_bad++;
            $display("FAIL single_grant: ack=%b nack=%b idx=%0d busy=%b cnt=%0d", ack, nack, grant_idx, busy, grant_cnt);
        end
        tick(4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy_end: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_not_ready();
        tick(4'b0001, 4'b0000);
        n_cmp++;
        if ({ack, nack, grant_cnt} !== {4'b0000, 4'b0000, m_cnt}) begin
            n_bad++;
            $display("FAIL not_ready: ack=%b nack=%b cnt=%0d, want 0000 0000 %0d", ack, nack, grant_cnt, m_cnt);
        end
        tick(4'hF, 4'hF);
        n_cmp++;
        if ({ack, grant_idx} !== {m_ack, m_gidx}) begin
            n_bad++;
            $display("FAIL not_ready_ptr: ack=%b idx=%0d, want %b %0d", ack, grant_idx, m_ack, m_gidx);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            tick(4'hF, 4'hF);
            n_cmp++;
            if ({ack, nack, grant_idx, busy, grant_cnt} !== {m_ack, m_nack, m_gidx, m_busy, m_cnt}) begin
                n_bad++;
                $display("FAIL round_robin e%0d: ack=%b nack=%b idx=%0d busy=%b cnt=%0d, want %b %b %0d %b %0d",
                         i, ack, nack, grant_idx, busy, grant_cnt, m_ack, m_nack, m_gidx, m_busy, m_cnt);
            end
        end
        n_cmp++;
        if (ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL round_robin_wrap: ack=%b, want 0001", ack);
        end
    endtask

    task automatic test_busy_retry();
        logic [3:0] want_ack [4] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010};
        logic [3:0] want_nack[4] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(4'b0010, 4'b0010);
            n_cmp++;
            if ({ack, nack} !== {want_ack[i], want_nack[i]}) begin
                n_bad++;
                $display("FAIL busy_retry e%0d: ack=%b nack=%b, want %b %b", i, ack, nack, want_ack[i], want_nack[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r, d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            tick(r, d);
            n_cmp++;
            if ({ack, nack, grant_idx, busy, grant_cnt} !== {m_ack, m_nack, m_gidx, m_busy, m_cnt}) begin
                n_bad++;
                $display("FAIL random e%0d: ack=%b nack=%b idx=%0d busy=%b cnt=%0d, want %b %b %0d %b %0d",
                         i, ack, nack, grant_idx, busy, grant_cnt, m_ack, m_nack, m_gidx, m_busy, m_cnt);
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] want_ack[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] want_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        req2 = 4'hF; rdy2 = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick(4'h0, 4'h0);
            n_cmp++;
            if ({ack2, nack2, busy2, grant_cnt2} !== {want_ack[i], ~want_ack[i], 1'b0, want_cnt[i]}) begin
                n_bad++;
                $display("FAIL saturate e%0d: ack=%b nack=%b busy=%b cnt=%0d, want %b %b 0 %0d",
                         i, ack2, nack2, busy2, grant_cnt2, want_ack[i], ~want_ack[i], want_cnt[i]);
            end
        end
        req2 = '0; rdy2 = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4'hF, 4'hF);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ack, busy, grant_cnt} !== 21'd0) begin
            n_bad++;
            $display("FAIL async_reset: ack=%b busy=%b cnt=%0d, want all 0", ack, busy, grant_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ack, nack, busy} !== 9'd0) begin
                n_bad++;
                $display("FAIL async_reset_hold: ack=%b nack=%b busy=%b, want 0", ack, nack, busy);
            end
        end
        rst = 1'b0;
        model_reset();
        tick(4'h0, 4'h0);
        n_cmp++;
        if ({ack, nack, busy} !== 9'd0) begin
            n_bad++;
            $display("FAIL async_reset_after: ack=%b nack=%b busy=%b, want 0", ack, nack, busy);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_not_ready();
        test_round_robin();
        test_busy_retry();
        test_random();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_req_ack_arbiter.md
Name: rr_req_ack_arbiter

Overview:
- Round-robin arbiter that shares one serviced resource among N requesters using a request/ready, then ack/nack protocol.
- Guarantee: whenever reset is low and a requester presents req&&rdy at a clock edge, exactly one of ack or nack is asserted to that requester at the next edge.
  - A winner sees ack=1, nack=0.
  - A loser or a requester that finds the resource busy sees ack=0, nack=1.
- The resource is then held busy for a fixed service time. The arbiter sits between the requester agents and the shared resource.

Parameters:
- N, 4: number of requesters (2..16).
- SVC_CYCLES, 3: clocks the resource stays occupied per grant, counting the grant edge (1..15).
- CNT_W, 16: width of the saturating grant counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  per-requester request.
- rdy  input  N  per-requester ready; a requester is eligible only when req[i]&&rdy[i].
- ack  output  N  registered one-cycle accept pulse, at most one bit set.
- nack  output  N  registered one-cycle reject pulse.
- grant_idx  output  $clog2(N)  index of the last winner, held until the next grant.
- busy  output  1  high while the resource is occupied after a grant.
- grant_cnt  output  CNT_W  total grants since reset, saturates at all-ones.

Behaviour:
- Reset: rst=1 asynchronously forces ack=0, nack=0, grant_idx=0, busy=0, grant_cnt=0, state=IDLE, rr pointer=0, service counter=0.
  - Reset asserted mid-service aborts the service. No ack/nack pulse is generated for the edge at which rst was high.
- Eligibility: elig = req & rdy, sampled at posedge. Requests with req=1, rdy=0 produce neither ack nor nack.
- ack and nack are pure registered pulses: each is high for exactly one cycle after the sampling edge, then returns to 0 unless re-triggered.
- States: IDLE, BUSY.
- IDLE, elig!=0 at edge t:
  - winner = first set bit of elig searching upward from the pointer, wrapping N-1 to 0.
  - Outputs after edge t: ack[winner]=1; nack = elig with the winner bit cleared; grant_idx=winner.
  - Pointer becomes (winner+1) mod N; grant_cnt increments (saturating).
  - If SVC_CYCLES>1: go to BUSY, load cnt=SVC_CYCLES-1, busy=1. If SVC_CYCLES=1: stay IDLE, busy stays 0.
- IDLE, elig==0: outputs ack=0, nack=0; no state change.
- BUSY, each edge:
  - nack=elig, ack=0.
  - If cnt==1: go to IDLE and set busy=0; otherwise decrement cnt.
  - Result: edges t+1 .. t+SVC_CYCLES-1 reject; earliest next grant is edge t+SVC_CYCLES.
- Invariants checked by assertions:
  - ack & nack == 0.
  - $onehot0(ack).
  - For all i: !rst && elig[i] |-> ##1 (ack[i] ^ nack[i]).
  - !elig[i] |-> ##1 !ack[i] && !nack[i].
- Wrap-around: the pointer at N-1 searches N-1, 0, 1, … The same requester wins back-to-back only if it is the only eligible one.
- The pointer does not move on edges without a grant.

Test Plan:
- Reset low; edge t with req=0001, rdy=0001 -> at t+1: ack=0001, nack=0000, grant_idx=0, busy=1, grant_cnt=1. At t+3 (SVC=3): busy=0.
- rst=1 with req=rdy=1111 -> ack=nack=0000, grant_cnt=0, across all edges while rst is high. Release rst -> first grant goes to index 0.
- req=0001, rdy=0000 at an idle edge -> ack=0000 and nack=0000 at the next edge; no grant, pointer unchanged.
- req=rdy=1111 held continuously, SVC=3 -> grants at edges t, t+3, t+6, t+9 to indices 0, 1, 2, 3, then index 0 again at t+12.
  - Non-winners receive nack on the grant edges.
  - On the two intervening edges of each service, nack=1111 and ack=0000.
- Grant to index 1 at edge t; req=rdy=0010 presented at t+1 -> nack=0010 at t+2. The same request wins at t+3 with ack=0010.
- Force grant_cnt to 16'hFFFE, then two grants -> grant_cnt=16'hFFFF, remaining 16'hFFFF after a third grant. Assert rst mid-BUSY -> busy=0 immediately (asynchronous), no pulse afterwards.
